spi_slave_core: RTL and testbench

Mode-0 SPI slave engine that sits directly downstream of the per-pin `stability_detector` filters on SCLK, CS_N and MOSI. Detects edges on the filtered, clk-domain pin levels, deserialises MOSI into words, and serialises words onto MISO. It presents a received-word strobe and a transmit holding register with a valid/ready handshake to the register/control logic.

---
 rtl/spi_slave_core_if.sv | 30 +++
 rtl/spi_slave_core.sv | 153 +++++++++++++++
 tb/tb_spi_slave_core.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_core_if.sv
// Register-side handshake of the SPI slave core: received-word strobe and
// transmit holding register with valid/ready.
interface spi_slave_core_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_underrun;

    modport slave (
        output rx_data,
        output rx_valid,
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_underrun
    );

    modport master (
        input  rx_data,
        input  rx_valid,
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_underrun
    );
endinterface

// File: rtl/spi_slave_core.sv
// Mode-0 SPI slave engine on filtered clk-domain pin levels: edge detect,
// MOSI deserialiser, MISO serialiser and one-deep transmit holding register.
module spi_slave_core #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk_in,
    input  logic                 cs_n_in,
    input  logic                 mosi_in,
    output logic                 miso_out,
    output logic                 miso_oe,
    spi_slave_core_if.slave      bus
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    state_e                state_q, state_d;
    logic                  sclk_q, cs_q;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  word_done_q, word_done_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  full_q, full_d;
    logic                  underrun_q, underrun_d;

    logic                  sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic                  tx_load;
    logic [DATA_WIDTH-1:0] rx_next;

    assign sclk_rise = sclk_in & ~sclk_q;
    assign sclk_fall = ~sclk_in & sclk_q;
    assign cs_fall   = ~cs_n_in & cs_q;
    assign cs_rise   = cs_n_in & ~cs_q;
    assign rx_next   = {rx_shift_q[DATA_WIDTH-2:0], mosi_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sclk_q      <= 1'b0;
            cs_q        <= 1'b1;
            bit_cnt_q   <= '0;
            word_done_q <= 1'b0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            full_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_q      <= sclk_in;
            cs_q        <= cs_n_in;
            bit_cnt_q   <= bit_cnt_d;
            word_done_q <= word_done_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            full_q      <= full_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_done_d = word_done_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        full_d      = full_q;
        underrun_d  = 1'b0;
        tx_load     = 1'b0;

        if (bus.tx_valid && !full_q) begin
            hold_d = bus.tx_data;
            full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d     = ACTIVE;
                    bit_cnt_d   = '0;
                    word_done_d = 1'b0;
                    tx_load     = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d     = IDLE;
                    bit_cnt_d   = '0;
                    word_done_d = 1'b0;
                    tx_shift_d  = '0;
                end else if (!cs_fall) begin
                    if (sclk_rise) begin
                        rx_shift_d = rx_next;
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_data_d   = rx_next;
                            rx_valid_d  = 1'b1;
                            bit_cnt_d   = '0;
                            word_done_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else if (sclk_fall) begin
                        // First fall after a completed word starts the next one.
                        if (word_done_q) begin
                            tx_load     = 1'b1;
                            word_done_d = 1'b0;
                        end else begin
                            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Consume only drains a full register, so it never collides with a capture.
        if (tx_load) begin
            if (full_q) begin
                tx_shift_d = hold_q;
                full_d     = 1'b0;
            end else begin
                tx_shift_d = '0;
                underrun_d = 1'b1;
            end
        end
    end

    assign miso_oe         = (state_q == ACTIVE);
    assign miso_out        = miso_oe & tx_shift_q[DATA_WIDTH-1];
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_ready    = ~full_q;
    assign bus.tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: drives SPI pins with slow mode-0 timing
// and checks received words, MISO bit streams and handshake strobes.
module tb_spi_slave_core;

    logic clk = 1'b0;
    logic rst;
    logic sclk_in, cs_n_in, mosi_in;
    logic miso_out, miso_oe;

    int checks = 0;
    int errors = 0;
    int rxv_cnt = 0;
    int udr_cnt = 0;

    spi_slave_core_if #(.DATA_WIDTH(8)) bus ();

    spi_slave_core #(.DATA_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk_in  (sclk_in),
        .cs_n_in  (cs_n_in),
        .mosi_in  (mosi_in),
        .miso_out (miso_out),
        .miso_oe  (miso_oe),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rx_valid)    rxv_cnt <= rxv_cnt + 1;
        if (bus.tx_underrun) udr_cnt <= udr_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        tick(1);
        bus.tx_valid = 1'b0;
    endtask

    // One SCLK period: low phase, MISO sampled just before the rise, high phase.
    task automatic spi_bit(input logic b, output logic s);
        mosi_in = b;
        tick(4);
        s = miso_out;
        sclk_in = 1'b1;
        tick(4);
        sclk_in = 1'b0;
    endtask

    task automatic spi_word(input logic [7:0] m, output logic [7:0] s);
        logic sb;
        s = '0;
        for (int i = 7; i >= 1; i--) begin
            spi_bit(m[i], sb);
            s[i] = sb;
        end
        mosi_in = m[0];
        tick(4);
        s[0] = miso_out;
        sclk_in = 1'b1;
        tick(1);
        check("rx_valid_strobe", 32'(bus.rx_valid), 32'd1);
        check("rx_data_word", 32'(bus.rx_data), 32'(m));
        tick(1);
        check("rx_valid_single", 32'(bus.rx_valid), 32'd0);
        tick(2);
        sclk_in = 1'b0;
    endtask

    task automatic cs_end();
        tick(4);
        cs_n_in = 1'b1;
        tick(4);
    endtask

    initial begin
        logic [7:0] got, got2;
        logic       sb;
        int         r0, u0;

        rst = 1'b1; cs_n_in = 1'b1; sclk_in = 1'b0; mosi_in = 1'b0;
        bus.tx_valid = 1'b0; bus.tx_data = '0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_miso_out", 32'(miso_out), 32'd0);
        check("rst_miso_oe", 32'(miso_oe), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_tx_underrun", 32'(bus.tx_underrun), 32'd0);

        // Plain receive of 0xA5
        r0 = rxv_cnt;
        cs_n_in = 1'b0;
        tick(4);
        spi_word(8'hA5, got);
        cs_end();
        check("rx_one_strobe", 32'(rxv_cnt - r0), 32'd1);
        check("rx_data_hold", 32'(bus.rx_data), 32'hA5);

        // Transmit 0x3C; a second push while full must be ignored
        push(8'h3C);
        check("tx_ready_after_load", 32'(bus.tx_ready), 32'd0);
        push(8'hFF);
        check("tx_ready_still_full", 32'(bus.tx_ready), 32'd0);
        cs_n_in = 1'b0;
        tick(1);
        check("tx_oe_after_csfall", 32'(miso_oe), 32'd1);
        check("tx_ready_after_consume", 32'(bus.tx_ready), 32'd1);
        check("tx_first_bit", 32'(miso_out), 32'd0);
        tick(3);
        spi_word(8'h00, got);
        check("tx_word_3c", 32'(got), 32'h3C);
        cs_end();
        check("tx_oe_after_csrise", 32'(miso_oe), 32'd0);

        // Back-to-back words with refill during word 1
        push(8'h81);
        u0 = udr_cnt;
        r0 = rxv_cnt;
        cs_n_in = 1'b0;
        tick(2);
        push(8'h7E);
        tick(1);
        spi_word(8'h11, got);
        spi_word(8'h22, got2);
        check("b2b_miso_w1", 32'(got), 32'h81);
        check("b2b_miso_w2", 32'(got2), 32'h7E);
        check("b2b_no_underrun", 32'(udr_cnt - u0), 32'd0);
        check("b2b_two_strobes", 32'(rxv_cnt - r0), 32'd2);
        cs_end();

        // Underrun: frame starts with holding register empty
        check("udr_ready_empty", 32'(bus.tx_ready), 32'd1);
        cs_n_in = 1'b0;
        tick(1);
        check("udr_strobe", 32'(bus.tx_underrun), 32'd1);
        tick(1);
        check("udr_single", 32'(bus.tx_underrun), 32'd0);
        tick(2);
        spi_word(8'h5A, got);
        check("udr_miso_zero", 32'(got), 32'h00);
        cs_end();

        // Abort after 5 bits, then a clean 0xF0 frame
        r0 = rxv_cnt;
        cs_n_in = 1'b0;
        tick(4);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, sb);
        cs_end();
        check("abort_no_strobe", 32'(rxv_cnt - r0), 32'd0);
        check("abort_rx_hold", 32'(bus.rx_data), 32'h5A);
        cs_n_in = 1'b0;
        tick(4);
        spi_word(8'hF0, got);
        cs_end();
        check("abort_next_word", 32'(bus.rx_data), 32'hF0);

        // CS rise coincident with the 8th SCLK rise: the edge must be dropped
        r0 = rxv_cnt;
        cs_n_in = 1'b0;
        tick(4);
        for (int i = 0; i < 7; i++) spi_bit(1'b0, sb);
        tick(4);
        cs_n_in = 1'b1;
        sclk_in = 1'b1;
        tick(3);
        check("same_cycle_no_strobe", 32'(rxv_cnt - r0), 32'd0);
        check("same_cycle_idle", 32'(miso_oe), 32'd0);
        sclk_in = 1'b0;
        tick(4);
        cs_n_in = 1'b0;
        tick(4);
        spi_word(8'hC3, got);
        cs_end();

        // Reset mid-frame with the holding register full
        push(8'h96);
        cs_n_in = 1'b0;
        tick(4);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, sb);
        push(8'h55);
        rst = 1'b1;
        tick(2);
        check("mrst_miso_out", 32'(miso_out), 32'd0);
        check("mrst_miso_oe", 32'(miso_oe), 32'd0);
        check("mrst_rx_data", 32'(bus.rx_data), 32'd0);
        check("mrst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("mrst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("mrst_tx_underrun", 32'(bus.tx_underrun), 32'd0);
        cs_n_in = 1'b1;
        rst = 1'b0;
        tick(2);
        check("mrst_idle_after", 32'(miso_oe), 32'd0);

        push(8'h69);
        cs_n_in = 1'b0;
        tick(4);
        spi_word(8'h96, got);
        check("post_rst_tx", 32'(got), 32'h69);
        cs_end();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
